// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite response codes and the byte-strobe merge helper
// used by the register slave.
package axi4lite_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_SLVERR = 2'b10;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_hold_slot.sv
// Single-entry holding register: load captures din and sets full,
// clear drops full. Load and clear are never requested together.
module axi_hold_slot #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic         full,
    output logic [W-1:0] dout
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            dout <= '0;
        end else if (load) begin
            full <= 1'b1;
            dout <= din;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register file slave: NREG 32-bit registers with independent AW/W
// capture, one outstanding write, pipelined reads and a parallel register view.
module axi4lite_reg_slave
    import axi4lite_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned NREG    = 8,
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    awaddr,
    input  logic [2:0]           awprot,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [31:0]          wdata,
    input  logic [3:0]           wstrb,
    input  logic                 wvalid,
    output logic                 wready,
    output logic [1:0]           bresp,
    output logic                 bvalid,
    input  logic                 bready,
    input  logic [ADDR_W-1:0]    araddr,
    input  logic [2:0]           arprot,
    input  logic                 arvalid,
    output logic                 arready,
    output logic [31:0]          rdata,
    output logic [1:0]           rresp,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [NREG*32-1:0]   regs_o
);

    localparam logic [ADDR_W-3:0] NREG_LIM = (ADDR_W-2)'(NREG);

    logic [31:0]       regs_q [NREG];
    logic              aw_full, w_full;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [35:0]       w_q;
    logic              commit, ar_hs;
    logic [ADDR_W-3:0] aw_idx, ar_idx;
    logic              aw_in_range, ar_in_range;
    logic [31:0]       rd_word;

    assign awready = ~aw_full;
    assign wready  = ~w_full;
    assign arready = ~rvalid | rready;
    assign commit  = aw_full & w_full & (~bvalid | bready);
    assign ar_hs   = arvalid & arready;

    assign aw_idx      = aw_addr_q[ADDR_W-1:2];
    assign ar_idx      = araddr[ADDR_W-1:2];
    assign aw_in_range = aw_idx < NREG_LIM;
    assign ar_in_range = ar_idx < NREG_LIM;

    axi_hold_slot #(.W(ADDR_W)) u_aw_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (awvalid & ~aw_full),
        .clear (commit),
        .din   (awaddr),
        .full  (aw_full),
        .dout  (aw_addr_q)
    );

    axi_hold_slot #(.W(36)) u_w_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (wvalid & ~w_full),
        .clear (commit),
        .din   ({wstrb, wdata}),
        .full  (w_full),
        .dout  (w_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= RST_VAL;
        end else if (commit && aw_in_range) begin
            for (int i = 0; i < NREG; i++) begin
                if (aw_idx == (ADDR_W-2)'(i)) begin
                    regs_q[i] <= strb_merge(regs_q[i], w_q[31:0], w_q[35:32]);
                end
            end
        end
    end

    // A commit in the same cycle as a B handshake keeps bvalid high for the new response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
        end else if (commit) begin
            bvalid <= 1'b1;
            bresp  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (bready) begin
            bvalid <= 1'b0;
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NREG; i++) begin
            if (ar_idx == (ADDR_W-2)'(i)) rd_word = regs_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= ar_in_range ? rd_word : 32'h0;
            rresp  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (rready) begin
            rvalid <= 1'b0;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_regs_o
        assign regs_o[32*g +: 32] = regs_q[g];
    end

    logic unused_bits;
    assign unused_bits = ^{awprot, arprot, aw_addr_q[1:0], araddr[1:0]};

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed self-checking bench for axi4lite_reg_slave (NREG=8).
module tb_axi4lite_reg_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [31:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [255:0] regs_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_r [8];

    axi4lite_reg_slave #(
        .ADDR_W  (32),
        .NREG    (8),
        .RST_VAL (32'h0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .awaddr  (awaddr),
        .awprot  (awprot),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arprot  (arprot),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .regs_o  (regs_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rg(input int i);
        return regs_o[32*i +: 32];
    endfunction

    // Same-cycle AW+W, then wait (bounded) for bvalid; returns in the bvalid cycle.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        awaddr = a; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 10) begin
            tick();
            n++;
        end
        chk("wr_bvalid_seen", {31'b0, bvalid}, 32'd1);
    endtask

    initial begin
        // Reset
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_awready", {31'b0, awready}, 32'd1);
        chk("rst_wready",  {31'b0, wready},  32'd1);
        chk("rst_arready", {31'b0, arready}, 32'd1);
        chk("rst_bvalid",  {31'b0, bvalid},  32'd0);
        chk("rst_rvalid",  {31'b0, rvalid},  32'd0);
        chk("rst_bresp",   {30'b0, bresp},   32'd0);
        chk("rst_rresp",   {30'b0, rresp},   32'd0);
        chk("rst_rdata",   rdata,            32'd0);
        for (int i = 0; i < 8; i++) chk("rst_reg", rg(i), 32'h0);

        // Write 0x08 with AW and W in the same cycle, latency check
        awaddr = 32'h08; awvalid = 1'b1;
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("w1_k1_awready", {31'b0, awready}, 32'd0);
        chk("w1_k1_wready",  {31'b0, wready},  32'd0);
        chk("w1_k1_bvalid",  {31'b0, bvalid},  32'd0);
        chk("w1_k1_reg2",    rg(2),            32'h0);
        tick();
        chk("w1_k2_bvalid",  {31'b0, bvalid},  32'd1);
        chk("w1_k2_bresp",   {30'b0, bresp},   32'd0);
        chk("w1_k2_reg2",    rg(2),            32'h12345678);
        tick();
        chk("w1_bclear",     {31'b0, bvalid},  32'd0);

        araddr = 32'h08; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("r1_rvalid", {31'b0, rvalid}, 32'd1);
        chk("r1_rdata",  rdata,           32'h12345678);
        chk("r1_rresp",  {30'b0, rresp},  32'd0);
        tick();
        chk("r1_rclear", {31'b0, rvalid}, 32'd0);

        // W ahead of AW with partial strobes on reg3
        do_write(32'h0C, 32'h11223344, 4'hF);
        tick();
        wdata = 32'hAABBCCDD; wstrb = 4'b0101; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("w2_wready_lo0", {31'b0, wready}, 32'd0);
        tick();
        chk("w2_wready_lo1", {31'b0, wready}, 32'd0);
        chk("w2_no_b1",      {31'b0, bvalid}, 32'd0);
        tick();
        chk("w2_wready_lo2", {31'b0, wready}, 32'd0);
        chk("w2_no_b2",      {31'b0, bvalid}, 32'd0);
        awaddr = 32'h0C; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("w2_wready_commit", {31'b0, wready}, 32'd0);
        chk("w2_no_b3",         {31'b0, bvalid}, 32'd0);
        tick();
        chk("w2_bvalid", {31'b0, bvalid}, 32'd1);
        chk("w2_bresp",  {30'b0, bresp},  32'd0);
        chk("w2_reg3",   rg(3),           32'h11BB33DD);
        tick();
        chk("w2_one_b",  {31'b0, bvalid}, 32'd0);
        chk("w2_wready", {31'b0, wready}, 32'd1);

        // Out-of-range write and read at 0x20
        do_write(32'h20, 32'hFFFFFFFF, 4'hF);
        chk("oor_bresp", {30'b0, bresp}, 32'd2);
        chk("oor_reg0",  rg(0), 32'h0);
        chk("oor_reg2",  rg(2), 32'h12345678);
        chk("oor_reg3",  rg(3), 32'h11BB33DD);
        chk("oor_reg7",  rg(7), 32'h0);
        tick();
        araddr = 32'h20; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        chk("oor_rvalid", {31'b0, rvalid}, 32'd1);
        chk("oor_rresp",  {30'b0, rresp},  32'd2);
        chk("oor_rdata",  rdata,           32'h0);
        tick();

        // B backpressure with a second write queued behind it
        bready = 1'b0;
        awaddr = 32'h10; awvalid = 1'b1;
        wdata = 32'hA0A0A0A0; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awaddr = 32'h14; wdata = 32'hB1B1B1B1;
        chk("bp_k1_awready", {31'b0, awready}, 32'd0);
        tick();
        chk("bp_k2_bvalid",  {31'b0, bvalid},  32'd1);
        chk("bp_k2_awready", {31'b0, awready}, 32'd1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold_awready", {31'b0, awready}, 32'd0);
            chk("bp_hold_wready",  {31'b0, wready},  32'd0);
            chk("bp_hold_bvalid",  {31'b0, bvalid},  32'd1);
            chk("bp_hold_bresp",   {30'b0, bresp},   32'd0);
            chk("bp_hold_reg5",    rg(5),            32'h0);
            tick();
        end
        bready = 1'b1;
        #1;
        chk("bp_rise_awready", {31'b0, awready}, 32'd0);
        tick();
        chk("bp_next_bvalid", {31'b0, bvalid},  32'd1);
        chk("bp_next_bresp",  {30'b0, bresp},   32'd0);
        chk("bp_reg4",        rg(4),            32'hA0A0A0A0);
        chk("bp_reg5",        rg(5),            32'hB1B1B1B1);
        chk("bp_awready",     {31'b0, awready}, 32'd1);
        tick();
        chk("bp_bclear", {31'b0, bvalid}, 32'd0);

        // Fill remaining registers, then back-to-back reads
        do_write(32'h00, 32'hC0DE0000, 4'hF); tick();
        do_write(32'h04, 32'h01010101, 4'hF); tick();
        do_write(32'h18, 32'h66666666, 4'hF); tick();
        do_write(32'h1C, 32'h77777777, 4'hF); tick();
        exp_r[0] = 32'hC0DE0000; exp_r[1] = 32'h01010101;
        exp_r[2] = 32'h12345678; exp_r[3] = 32'h11BB33DD;
        exp_r[4] = 32'hA0A0A0A0; exp_r[5] = 32'hB1B1B1B1;
        exp_r[6] = 32'h66666666; exp_r[7] = 32'h77777777;
        araddr = 32'h00; arvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("b2b_rvalid", {31'b0, rvalid}, 32'd1);
            chk("b2b_rdata",  rdata,           exp_r[i]);
            if (i < 7) araddr = 32'((i + 1) * 4);
        end
        araddr = 32'h08; rready = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            chk("stall_arready", {31'b0, arready}, 32'd0);
            chk("stall_rvalid",  {31'b0, rvalid},  32'd1);
            chk("stall_rdata",   rdata,            32'h77777777);
            tick();
        end
        rready = 1'b1;
        #1;
        chk("stall_release_arready", {31'b0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        chk("stall_next_rdata", rdata, 32'h12345678);
        tick();
        chk("stall_rclear", {31'b0, rvalid}, 32'd0);

        // Reset with AW captured but W never sent
        awaddr = 32'h04; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("mid_awready_lo", {31'b0, awready}, 32'd0);
        rst = 1'b1;
        #2;
        chk("mid_rst_awready", {31'b0, awready}, 32'd1);
        chk("mid_rst_bvalid",  {31'b0, bvalid},  32'd0);
        chk("mid_rst_reg2",    rg(2),            32'h0);
        chk("mid_rst_reg7",    rg(7),            32'h0);
        tick();
        rst = 1'b0;
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tick();
        chk("mid_no_commit0", {31'b0, bvalid}, 32'd0);
        tick();
        chk("mid_no_commit1", {31'b0, bvalid}, 32'd0);
        chk("mid_reg1_rst",   rg(1),           32'h0);
        awaddr = 32'h04; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tick();
        chk("mid_post_bvalid", {31'b0, bvalid}, 32'd1);
        chk("mid_post_bresp",  {30'b0, bresp},  32'd0);
        chk("mid_post_reg1",   rg(1),           32'hDEADBEEF);
        chk("mid_post_reg0",   rg(0),           32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4lite_reg_slave.md
# axi4lite_reg_slave

AXI4-Lite slave register file with NREG 32-bit read/write registers. It sits directly downstream of the AXI4-Lite master example and serves as its target memory for the read-modify-write sweep over word addresses 0..NREG-1. It also exposes all register contents in parallel to fabric logic. Address and write-data channels are accepted independently; the block supports one outstanding write and one pipelined read.

## Interface
- ADDR_W, 32, AXI address width
- NREG, 8, number of 32-bit registers (1..256)
- RST_VAL, 32'h0, reset value of every register
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- awaddr  in  ADDR_W  write address
- awprot  in  3  ignored
- awvalid / awready  in / out  1  AW handshake
- wdata  in  32  write data
- wstrb  in  4  byte strobes
- wvalid / wready  in / out  1  W handshake
- bresp  out  2  write response
- bvalid / bready  out / in  1  B handshake
- araddr  in  ADDR_W  read address
- arprot  in  3  ignored
- arvalid / arready  in / out  1  AR handshake
- rdata  out  32  read data
- rresp  out  2  read response
- rvalid / rready  out / in  1  R handshake
- regs_o  out  NREG*32  register contents; reg i is at bits [32i+31:32i]

## Operation
- Register index = addr[ADDR_W-1:2]; addr[1:0] ignored. The access is in range iff index < NREG.
- Write path: two holding slots, aw_full and w_full, each with a captured value.
  - awready = ~aw_full; wready = ~w_full (combinational).
  - A handshake loads the slot. AW and W may arrive in either order, any distance apart.
- Commit condition: aw_full & w_full & (~bvalid | bready).
- On commit:
  - In range: byte b of reg[index] is updated where wstrb[b]=1; bresp=2'b00 (OKAY).
  - Out of range: no register changes; bresp=2'b10 (SLVERR).
  - bvalid is set and both slots are cleared.
- bvalid clears on bvalid & bready, unless a commit happens in the same cycle, in which case bvalid stays set with the new bresp.
- Read path: arready = ~rvalid | rready. On AR handshake:
  - In range: rdata = reg[index], rresp = OKAY.
  - Out of range: rdata = 0, rresp = SLVERR.
  - rvalid is set.
- rvalid clears on rvalid & rready when no new AR handshake occurs that cycle.
- Read of a register committed in the same cycle returns the old value.
- regs_o is a direct register output with no extra delay.

## Timing
- Reset values: awready=1, wready=1, arready=1 (once rst is released), bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, all registers=RST_VAL.
- Reset asserted mid-transaction discards captured AW/W, pending B and pending R. No partial write is performed.
- Write latency: AW and W both handshaken in cycle k → commit in cycle k+1 → bvalid and the updated regs_o visible in cycle k+2.
  - awready and wready are low in cycle k+1.
  - Sustained throughput is one write per 2 cycles.
- Read latency: AR handshake in cycle k → rvalid and rdata in cycle k+1.
  - With rready=1 held, one read completes per cycle.
- While bvalid & ~bready, no commit occurs. Slots stay full, and awready/wready stay low once filled.
- rdata and rresp hold stable while rvalid & ~rready.

## Structure
- Package axi4lite_pkg holds:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - typedef axi_resp_t (logic [1:0])
  - function strb_merge(old, new, strb) returning the byte-masked 32-bit word
- One natural sub-module: axi_hold_slot, a single-entry valid/data holding register with a load/clear interface. It is instantiated twice, for AW (ADDR_W bits) and W (36 bits: data plus strobes).
- The register array, commit logic and read mux live in the top module.

## Test plan
- AW(addr 0x08) and W(0x12345678, strb 4'hF) handshaken in the same cycle k, bready=1 → bvalid in cycle k+2 with bresp 00; regs_o reg2 = 0x12345678; then read 0x08 → rvalid one cycle after AR, rdata 0x12345678, rresp 00.
- W(0xAABBCCDD, strb 4'b0101) issued 3 cycles before AW(0x0C) on reg3 = 0x11223344 → wready low from W handshake until commit; reg3 = 0x11BB33DD; exactly one B.
- NREG=8, write and read at 0x20 → bresp 10, no register changes; rresp 10, rdata 0.
- bready held low 5 cycles after a B, while a second AW/W pair is offered → slots fill then awready/wready stay low; bvalid and bresp stable; second commit occurs in the cycle bready rises, and bvalid remains high into the next response.
- Back-to-back reads of 0x00..0x1C with rready=1 → 8 consecutive rvalid cycles returning reg0..reg7 in order. Then rready low for 3 cycles → rdata held and arready low.
- rst pulsed after AW accepted but before W → bvalid stays 0, all registers = RST_VAL, awready=1. A subsequent full write completes normally.
